// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the frame buffer read path: unpacker state encoding
// and the residue-register width derivation.
package frame_buffer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } unpack_state_t;

   // Worst case residue: PIX_W-8 leftover bits plus one freshly appended word.
   function automatic int acc_width(input int bus_w, input int pix_w);
      return bus_w + pix_w - 8;
   endfunction

endpackage

// File: rtl/dma_byte_swap.sv
// Combinational byte reverser for one pixel; passes the pixel through
// unchanged when swap_en is low.
module dma_byte_swap #(
   parameter int PIX_W = 24
) (
   input  logic             swap_en,
   input  logic [PIX_W-1:0] pix,
   output logic [PIX_W-1:0] pix_swapped
);

   localparam int NB = PIX_W / 8;

   logic [PIX_W-1:0] rev;

   for (genvar gi = 0; gi < NB; gi++) begin : g_rev
      assign rev[8*gi +: 8] = pix[8*(NB-1-gi) +: 8];
   end

   assign pix_swapped = swap_en ? rev : pix;

endmodule

// File: rtl/dma_word_unpacker.sv
// Unpacks BUS_W-bit DDR read words into PIX_W-bit pixels with per-line
// pixel counting, last-pixel marking and residue discard at end of line.
module dma_word_unpacker
   import frame_buffer_pkg::*;
#(
   parameter int BUS_W = 32,
   parameter int PIX_W = 24,
   parameter int CNT_W = 16
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             sol,
   input  logic [CNT_W-1:0] line_pix,
   input  logic             swap_en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BUS_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int ACC_W = acc_width(BUS_W, PIX_W);
   localparam int LVL_W = $clog2(ACC_W + 1);
   localparam logic [LVL_W-1:0] PIX_LVL = LVL_W'(PIX_W);
   localparam logic [LVL_W-1:0] BUS_LVL = LVL_W'(BUS_W);

   unpack_state_t    state;
   logic [ACC_W-1:0] acc;
   logic [LVL_W-1:0] lvl;
   logic [CNT_W-1:0] cnt;
   logic             swap_q;

   logic             run;
   logic             last_pix;
   logic             out_fire;
   logic             in_fire;
   logic [LVL_W-1:0] lvl_pop;
   logic [LVL_W-1:0] lvl_app;
   logic [ACC_W-1:0] acc_pop;
   logic [ACC_W-1:0] acc_app;

   // Handshakes: a transfer happens in a cycle where valid && ready; valid never
   // depends on ready. in_ready depends on out_ready so a pop frees room for a
   // word in the same cycle. A sol cycle blocks both sides so nothing from the
   // aborted line is transferred.
   assign run       = (state == ST_RUN);
   assign last_pix  = (cnt == CNT_W'(1));
   assign out_valid = run && !sol && (lvl >= PIX_LVL);
   assign out_fire  = out_valid && out_ready;
   assign out_last  = run && last_pix;

   assign lvl_pop   = out_fire ? (lvl - PIX_LVL) : lvl;
   assign acc_pop   = out_fire ? (acc >> PIX_W) : acc;

   // No word is taken on the final pop: its bytes would belong to the next line.
   assign in_ready  = run && !sol && (lvl_pop < PIX_LVL) && !(out_fire && last_pix);
   assign in_fire   = in_valid && in_ready;

   assign acc_app   = acc_pop | (ACC_W'(in_data) << lvl_pop);
   assign lvl_app   = lvl_pop + BUS_LVL;

   dma_byte_swap #(
      .PIX_W (PIX_W)
   ) u_swap (
      .swap_en     (swap_q),
      .pix         (acc[PIX_W-1:0]),
      .pix_swapped (out_data)
   );

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         acc    <= '0;
         lvl    <= '0;
         cnt    <= '0;
         swap_q <= 1'b0;
      end else if (sol) begin
         swap_q <= swap_en;
         cnt    <= line_pix;
         acc    <= '0;
         lvl    <= '0;
         if (line_pix != '0) begin
            state <= ST_RUN;
            busy  <= 1'b1;
         end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end
      end else if (run) begin
         if (out_fire && last_pix) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            acc   <= '0;
            lvl   <= '0;
            cnt   <= '0;
         end else begin
            if (out_fire) begin
               cnt <= cnt - CNT_W'(1);
            end
            acc <= in_fire ? acc_app : acc_pop;
            lvl <= in_fire ? lvl_app : lvl_pop;
         end
      end
   end

endmodule

// File: tb/tb_dma_word_unpacker.sv
// Directed bench for dma_word_unpacker: a 32/24 instance for the hand-computed
// vectors and a 64/24 instance for the long randomised-handshake line.
module tb_dma_word_unpacker;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        sol;
   logic [15:0] line_pix;
   logic        swap_en;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_out_last, a_busy;
   logic [23:0] a_out_data;
   logic        b_in_ready, b_out_valid, b_out_last, b_busy;
   logic [23:0] b_out_data;

   logic        o_in_ready, o_out_valid, o_out_last, o_busy;
   logic [23:0] o_out_data;

   int          n_cmp = 0;
   int          n_mis = 0;
   string       cur_test = "reset";
   int          last_fires;
   int          last_widx;

   logic [63:0] words[$];
   logic [23:0] exp_q[$];
   logic        exp_last_q[$];
   logic [7:0]  bstream[5760];

   always #5 sys_clk = ~sys_clk;

   dma_word_unpacker #(.BUS_W(32), .PIX_W(24), .CNT_W(16)) u_dut32 (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .sol       (sol & ~sel),
      .line_pix  (line_pix),
      .swap_en   (swap_en),
      .in_valid  (in_valid & ~sel),
      .in_ready  (a_in_ready),
      .in_data   (in_data[31:0]),
      .out_valid (a_out_valid),
      .out_ready (out_ready & ~sel),
      .out_data  (a_out_data),
      .out_last  (a_out_last),
      .busy      (a_busy)
   );

   dma_word_unpacker #(.BUS_W(64), .PIX_W(24), .CNT_W(16)) u_dut64 (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .sol       (sol & sel),
      .line_pix  (line_pix),
      .swap_en   (swap_en),
      .in_valid  (in_valid & sel),
      .in_ready  (b_in_ready),
      .in_data   (in_data),
      .out_valid (b_out_valid),
      .out_ready (out_ready & sel),
      .out_data  (b_out_data),
      .out_last  (b_out_last),
      .busy      (b_busy)
   );

   assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
   assign o_out_valid = sel ? b_out_valid : a_out_valid;
   assign o_out_data  = sel ? b_out_data  : a_out_data;
   assign o_out_last  = sel ? b_out_last  : a_out_last;
   assign o_busy      = sel ? b_busy      : a_busy;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_mis++;
         $error("FAIL %s/%s: got 0x%0h, want 0x%0h", cur_test, tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_sol(input logic [15:0] lp, input logic sw);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sol       = 1'b1;
      line_pix  = lp;
      swap_en   = sw;
      tick();
      sol       = 1'b0;
   endtask

   // Feeds words[] and drains exp_q/exp_last_q; first_fire < 0 skips the latency check.
   task automatic run_line(input int max_cyc, input bit rnd, input int first_fire);
      int          widx = 0;
      int          cyc = 0;
      int          fires = 0;
      bit          held = 1'b0;
      logic [23:0] held_data = '0;
      logic        held_last = 1'b0;
      while (exp_q.size() > 0 && cyc < max_cyc) begin
         in_valid  = (widx < words.size()) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         in_data   = (widx < words.size()) ? words[widx] : 64'h0;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge sys_clk);
         if (held) begin
            check("stall_valid", 64'(o_out_valid), 64'(1'b1));
            check("stall_data", 64'(o_out_data), 64'(held_data));
            check("stall_last", 64'(o_out_last), 64'(held_last));
         end
         if (o_out_valid && out_ready) begin
            if (first_fire >= 0 && fires == 0) check("latency", 64'(cyc), 64'(first_fire));
            check("pix", 64'(o_out_data), 64'(exp_q.pop_front()));
            check("last", 64'(o_out_last), 64'(exp_last_q.pop_front()));
            fires++;
         end
         held      = o_out_valid && !out_ready;
         held_data = o_out_data;
         held_last = o_out_last;
         if (in_valid && o_in_ready) widx++;
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("drained", 64'(exp_q.size()), 64'(0));
      last_fires = fires;
      last_widx  = widx;
   endtask

   task automatic push_pix(input logic [23:0] p, input logic l);
      exp_q.push_back(p);
      exp_last_q.push_back(l);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sel = 1'b0; sol = 1'b0; line_pix = '0; swap_en = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // Reset state of both instances
      tick(); tick();
      check("a_in_ready", 64'(a_in_ready), 64'(0));
      check("a_out_valid", 64'(a_out_valid), 64'(0));
      check("a_out_data", 64'(a_out_data), 64'(0));
      check("a_out_last", 64'(a_out_last), 64'(0));
      check("a_busy", 64'(a_busy), 64'(0));
      check("b_busy", 64'(b_busy), 64'(0));
      check("b_out_valid", 64'(b_out_valid), 64'(0));
      rst = 1'b0;
      tick();

      // Basic line of 4 pixels
      cur_test = "line4";
      do_sol(16'd4, 1'b0);
      check("busy_on", 64'(o_busy), 64'(1));
      words = '{64'h44332211, 64'h88776655, 64'hCCBBAA99};
      push_pix(24'h332211, 1'b0); push_pix(24'h665544, 1'b0);
      push_pix(24'h998877, 1'b0); push_pix(24'hCCBBAA, 1'b1);
      run_line(40, 1'b0, 1);
      check("busy_off", 64'(o_busy), 64'(0));
      check("words_used", 64'(last_widx), 64'(3));

      // Same line with byte swap
      cur_test = "swap";
      do_sol(16'd4, 1'b1);
      push_pix(24'h112233, 1'b0); push_pix(24'h445566, 1'b0);
      push_pix(24'h778899, 1'b0); push_pix(24'hAABBCC, 1'b1);
      run_line(40, 1'b0, 1);
      check("busy_off", 64'(o_busy), 64'(0));

      // Short line: residue discarded, block idles until next sol
      cur_test = "line3";
      do_sol(16'd3, 1'b0);
      push_pix(24'h332211, 1'b0); push_pix(24'h665544, 1'b0); push_pix(24'h998877, 1'b1);
      run_line(40, 1'b0, 1);
      in_valid = 1'b1; in_data = 64'h00FFEEDD; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         check("idle_in_ready", 64'(o_in_ready), 64'(0));
         check("idle_out_valid", 64'(o_out_valid), 64'(0));
         tick();
      end
      do_sol(16'd1, 1'b0);
      words = '{64'h00FFEEDD};
      push_pix(24'hFFEEDD, 1'b1);
      run_line(40, 1'b0, 1);
      check("busy_off", 64'(o_busy), 64'(0));

      // Mid-line restart: pending pixel dropped, count reloaded
      cur_test = "restart";
      do_sol(16'd4, 1'b0);
      words = '{64'h44332211, 64'h88776655, 64'hCCBBAA99};
      push_pix(24'h332211, 1'b0); push_pix(24'h665544, 1'b0);
      run_line(40, 1'b0, 1);
      do_sol(16'd4, 1'b0);
      check("dropped", 64'(o_out_valid), 64'(0));
      check("busy", 64'(o_busy), 64'(1));
      words = '{64'h0A0B0C0D, 64'h14131211, 64'h18171615};
      push_pix(24'h0B0C0D, 1'b0); push_pix(24'h12110A, 1'b0);
      push_pix(24'h151413, 1'b0); push_pix(24'h181716, 1'b1);
      run_line(40, 1'b0, 1);
      check("busy_off", 64'(o_busy), 64'(0));

      // Asynchronous reset with a pixel pending
      cur_test = "async_rst";
      do_sol(16'd4, 1'b0);
      in_valid = 1'b1; in_data = 64'h44332211; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      check("pending", 64'(o_out_valid), 64'(1));
      #2 rst = 1'b1;
      #1;
      check("in_ready", 64'(a_in_ready), 64'(0));
      check("out_valid", 64'(a_out_valid), 64'(0));
      check("out_data", 64'(a_out_data), 64'(0));
      check("out_last", 64'(a_out_last), 64'(0));
      check("busy", 64'(a_busy), 64'(0));
      @(negedge sys_clk);
      rst = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_in_ready", 64'(o_in_ready), 64'(0));
         check("post_out_valid", 64'(o_out_valid), 64'(0));
         check("post_busy", 64'(o_busy), 64'(0));
      end
      in_valid = 1'b0; out_ready = 1'b0;

      // 1920-pixel line on the 64-bit instance with random handshakes
      cur_test = "long64";
      sel = 1'b1;
      for (int i = 0; i < 5760; i++) bstream[i] = 8'($urandom_range(0, 255));
      words.delete();
      for (int k = 0; k < 720; k++) begin
         logic [63:0] w;
         for (int j = 0; j < 8; j++) w[8*j +: 8] = bstream[8*k + j];
         words.push_back(w);
      end
      for (int p = 0; p < 1920; p++)
         push_pix({bstream[3*p+2], bstream[3*p+1], bstream[3*p]}, p == 1919);
      do_sol(16'd1920, 1'b0);
      run_line(20000, 1'b1, -1);
      check("fires", 64'(last_fires), 64'(1920));
      check("words_used", 64'(last_widx), 64'(720));
      check("busy_off", 64'(o_busy), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/dma_word_unpacker.md
# dma_word_unpacker

Parametrised successor to the fixed 32-to-24-bit DMA unpacker in the frame buffer read path. It converts a stream of BUS_W-bit words from the DDR read FIFO into PIX_W-bit pixels for the video output side. It adds valid/ready flow control on both sides, a per-line pixel count with last-pixel marking and residue discard, and an optional byte swap within each pixel. Line alignment is re-established on every start-of-line pulse.

## Interface
Parameters:
- BUS_W, 32: input word width in bits; multiple of 8, 16 to 128.
- PIX_W, 24: pixel width in bits; multiple of 8, 8 ≤ PIX_W ≤ BUS_W.
- CNT_W, 16: width of the line pixel counter.

Ports:
- sys_clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high. One clock; reset is asynchronous and active-high.
- sol  in  1  start-of-line pulse; clears alignment and arms a new line.
- line_pix  in  CNT_W  pixels per line; sampled on sol.
- swap_en  in  1  reverse byte order inside each output pixel; sampled on sol.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  BUS_W  packed pixels; first byte in time is bits [7:0].
- out_valid  out  1  pixel available.
- out_ready  in  1  downstream accepts the pixel.
- out_data  out  PIX_W  pixel.
- out_last  out  1  qualifies the last pixel of the line.
- busy  out  1  high in RUN.

## Operation
- Residue register acc, ACC_W = BUS_W + PIX_W − 8 bits. Level lvl counts valid bits (0..ACC_W), in byte steps. Bytes are consumed LSB first.
- State machine with states IDLE and RUN.
  - IDLE → RUN on sol with line_pix ≠ 0. sol with line_pix = 0 leaves the block in IDLE.
  - RUN → IDLE on the fire of the pixel with out_last.
  - sol in RUN aborts the line and restarts it: acc and lvl are cleared, the count is reloaded, and the block stays in RUN. Any pixel pending on out_data is dropped.
- In RUN:
  - out_valid = (lvl ≥ PIX_W).
  - out_data = acc[PIX_W−1:0], byte-reversed when swap_en is latched.
  - in_ready = ((lvl − (out_fire ? PIX_W : 0)) < PIX_W). This is a combinational path from out_ready to in_ready; it is intentional.
- Per cycle, pop (if out_fire) happens first, then append (if in_fire): acc = (acc >> PIX_W·pop) | (in_data << lvl_after_pop), and lvl updates accordingly.
- A pixel counter loads line_pix on sol and decrements on each out_fire. out_last = (counter == 1).
- On the out_last fire, acc and lvl are cleared. Unused bytes of the final word are discarded.
- In IDLE, in_ready = 0 and out_valid = 0. Words offered between lines stay in the FIFO.
- Reset values: in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, state IDLE, lvl 0, acc 0, latched swap_en 0.

## Timing
- The first pixel is valid 1 cycle after the first word is accepted. There is no combinational in_data → out_data path.
- sol in cycle n: in_ready can be high in cycle n+1.
- Steady-state throughput is 1 pixel/cycle whenever input is available and out_ready is high (BUS_W ≥ PIX_W guarantees this).
- Stall rule: out_valid is held with out_data and out_last stable until out_ready. in_valid may drop at any time.
- When lvl is still ≥ PIX_W after a pop, in_ready stays low. No overflow is possible.

## Structure
- Shared package (frame_buffer_pkg): state encoding (IDLE = 1'b0, RUN = 1'b1) and the ACC_W derivation function.
- Sub-module dma_byte_swap: a combinational PIX_W byte reverser gated by swap_en. Everything else (FSM, counter, acc) lives in the top module.

## Test plan
- BUS_W=32, PIX_W=24, line_pix=4.
  - Stimulus: words 0x44332211, 0x88776655, 0xCCBBAA99, with out_ready held high.
  - Required: pixels 0x332211, 0x665544, 0x998877, 0xCCBBAA. out_last on the 4th pixel. busy falls the next cycle.
- Same as above with swap_en=1 latched at sol.
  - Required: 0x112233, 0x445566, 0x778899, 0xAABBCC.
- line_pix=3, same words.
  - Required: after 0x998877 (out_last), the 0xAA/0xBB/0xCC residue is discarded and in_ready stays 0 until the next sol.
  - The next line's first word 0x00FFEEDD yields 0xFFEEDD.
- Random out_ready (50%) and random in_valid gaps over a 1920-pixel line at BUS_W=64, PIX_W=24.
  - Required: pixel sequence matches the reference byte stream; exactly 1920 fires; out_data is stable while stalled.
- sol asserted mid-line after 2 pixels with a new word 0x0A0B0C0D.
  - Required: the next pixel is 0x0B0C0D and the count restarts from line_pix.
- rst asserted mid-line with out_valid high.
  - Required: all outputs go to 0 asynchronously. After release, nothing is produced until sol.
